// File: rtl/morse_pkg.sv
// Shared encodings for the Morse symbol capture block:
// symbol event codes and capture FSM states.
package morse_pkg;

   typedef enum logic [1:0] {
      SYM_GAP  = 2'b00,
      SYM_DOT  = 2'b01,
      SYM_DASH = 2'b10,
      SYM_STOP = 2'b11
   } sym_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PRESS = 2'b01,
      ST_SPACE = 2'b10
   } state_t;

endpackage

// File: rtl/morse_led_render.sv
// Draws the letter under assembly on the LED bar, first symbol at the MSB:
// DOT = 1 lit bit, DASH = 3 lit bits, one dark bit after each symbol.
module morse_led_render
   import morse_pkg::*;
#(
   parameter int MAX_SYMBOLS = 6,
   parameter int LED_W       = 16,
   parameter int CNT_W       = $clog2(MAX_SYMBOLS + 1)
) (
   input  logic [2*MAX_SYMBOLS-1:0] sym_buf_i,
   input  logic [CNT_W-1:0]         cnt_i,
   output logic [LED_W-1:0]         led_o
);

   int   free;
   sym_t sym;

   always_comb begin
      led_o = '0;
      free  = LED_W;
      sym   = SYM_GAP;
      for (int i = 0; i < MAX_SYMBOLS; i++) begin
         if (i < int'(cnt_i)) begin
            sym = sym_t'(2'(sym_buf_i >> (2 * (int'(cnt_i) - 1 - i))));
            // Once a symbol fails to fit, nothing after it is drawn.
            if (sym == SYM_DASH) begin
               if (free >= 3) begin
                  led_o = led_o | (LED_W'(7) << (free - 3));
                  free  = free - 4;
               end else begin
                  free = 0;
               end
            end else begin
               if (free >= 1) begin
                  led_o = led_o | (LED_W'(1) << (free - 1));
                  free  = free - 2;
               end else begin
                  free = 0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/morse_symbol_capture.sv
// Morse key capture: classifies presses into DOT/DASH, assembles letters,
// hands them to a valid/ready consumer and flags word gaps.
module morse_symbol_capture
   import morse_pkg::*;
#(
   parameter int DASH_TICKS       = 70,
   parameter int SAT_TICKS        = 100,
   parameter int LETTER_GAP_TICKS = 150,
   parameter int WORD_GAP_TICKS   = 350,
   parameter int MAX_SYMBOLS      = 6,
   parameter int LED_W            = 16
) (
   input  logic                         clock100Hz,
   input  logic                         clear,
   input  logic                         btnR,
   input  logic                         btnL,
   output logic [1:0]                   type_o,
   output logic                         letter_valid,
   input  logic                         letter_ready,
   output logic [2*MAX_SYMBOLS-1:0]     letter_code,
   output logic [$clog2(MAX_SYMBOLS+1)-1:0] letter_len,
   output logic                         word_gap,
   output logic                         overflow,
   output logic [LED_W-1:0]             led
);

   localparam int CW = $clog2(SAT_TICKS * 4 + 1);
   localparam int LW = $clog2(MAX_SYMBOLS + 1);
   localparam int BW = 2 * MAX_SYMBOLS;
   localparam logic [CW-1:0] PRESS_MAX = CW'(SAT_TICKS);
   localparam logic [CW-1:0] GAP_MAX   = CW'(SAT_TICKS * 4);
   localparam logic [CW-1:0] DASH_MIN  = CW'(DASH_TICKS);
   localparam logic [CW-1:0] LGAP      = CW'(LETTER_GAP_TICKS);
   localparam logic [CW-1:0] WGAP      = CW'(WORD_GAP_TICKS);
   localparam logic [LW-1:0] CNT_MAX   = LW'(MAX_SYMBOLS);

   state_t           state_q, state_d;
   logic             key_q, flush_q, armed_q;
   logic [CW-1:0]    press_q, press_d, gap_q, gap_d, gap_nxt;
   logic [BW-1:0]    buf_q, buf_d, code_q, code_d;
   logic [LW-1:0]    cnt_q, cnt_d, len_q, len_d;
   sym_t             type_q, type_d, sym;
   logic             lv_q, lv_d, wg_q, wg_d;
   logic             ovf_q, ovf_d, wpend_q, wpend_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             key_rise, key_fall, flush_rise;

   // A key held through reset must be seen low before a press can start.
   assign key_rise   = btnR & ~key_q & armed_q;
   assign key_fall   = ~btnR & key_q;
   assign flush_rise = btnL & ~flush_q;
   assign gap_nxt    = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;

   always_ff @(posedge clock100Hz) begin
      if (!clear) begin
         state_q <= ST_IDLE;
         key_q   <= 1'b0;
         flush_q <= 1'b0;
         armed_q <= ~btnR;
         press_q <= '0;
         gap_q   <= '0;
         buf_q   <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         len_q   <= '0;
         type_q  <= SYM_STOP;
         lv_q    <= 1'b0;
         wg_q    <= 1'b0;
         ovf_q   <= 1'b0;
         wpend_q <= 1'b0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= btnR;
         flush_q <= btnL;
         armed_q <= armed_q | ~btnR;
         press_q <= press_d;
         gap_q   <= gap_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         len_q   <= len_d;
         type_q  <= type_d;
         lv_q    <= lv_d;
         wg_q    <= wg_d;
         ovf_q   <= ovf_d;
         wpend_q <= wpend_d;
         led_q   <= led_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (key_rise) begin
         state_d = ST_PRESS;
      end else begin
         unique case (state_q)
            ST_PRESS: if (key_fall) state_d = ST_SPACE;
            ST_SPACE: if (gap_nxt == WGAP) state_d = ST_IDLE;
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      press_d = press_q;
      gap_d   = '0;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      len_d   = len_q;
      type_d  = SYM_STOP;
      lv_d    = lv_q;
      wg_d    = 1'b0;
      ovf_d   = ovf_q;
      wpend_d = wpend_q;
      sym     = (press_q < DASH_MIN) ? SYM_DOT : SYM_DASH;

      if (key_rise) begin
         press_d = CW'(1);
      end else if (state_q == ST_PRESS && btnR) begin
         press_d = (press_q >= PRESS_MAX) ? PRESS_MAX : press_q + 1'b1;
      end

      if (state_q == ST_PRESS && key_fall) begin
         gap_d = CW'(1);
      end else if (state_q == ST_SPACE && !key_rise) begin
         gap_d = gap_nxt;
      end

      if (lv_q && letter_ready) begin
         lv_d  = 1'b0;
         ovf_d = 1'b0;
      end

      if (state_q == ST_PRESS && key_fall && !flush_rise) begin
         type_d = sym;
         if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            buf_d = {buf_q[BW-3:0], sym};
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (state_q == ST_SPACE && !key_rise && !flush_rise) begin
         if (gap_nxt == LGAP && cnt_q != '0) begin
            type_d  = SYM_GAP;
            wpend_d = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            if (lv_q) begin
               ovf_d = 1'b1;
            end else begin
               lv_d   = 1'b1;
               code_d = buf_q;
               len_d  = cnt_q;
            end
         end
         if (gap_nxt == WGAP && wpend_q) begin
            wg_d    = 1'b1;
            wpend_d = 1'b0;
         end
      end

      if (flush_rise) begin
         buf_d   = '0;
         cnt_d   = '0;
         press_d = key_rise ? CW'(1) : '0;
         type_d  = SYM_GAP;
      end
   end

   morse_led_render #(
      .MAX_SYMBOLS (MAX_SYMBOLS),
      .LED_W       (LED_W),
      .CNT_W       (LW)
   ) u_led (
      .sym_buf_i (buf_d),
      .cnt_i     (cnt_d),
      .led_o     (led_d)
   );

   assign type_o       = type_q;
   assign letter_valid = lv_q;
   assign letter_code  = code_q;
   assign letter_len   = len_q;
   assign word_gap     = wg_q;
   assign overflow     = ovf_q;
   assign led          = led_q;

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Directed bench for morse_symbol_capture: press table plus
// hand-written letter, overflow, flush and reset sequences.
module tb_morse_symbol_capture;

   logic        clock100Hz = 1'b0;
   logic        clear = 1'b0;
   logic        btnR = 1'b0;
   logic        btnL = 1'b0;
   logic        letter_ready = 1'b0;
   logic [1:0]  type_o;
   logic        letter_valid;
   logic [11:0] letter_code;
   logic [2:0]  letter_len;
   logic        word_gap;
   logic        overflow;
   logic [15:0] led;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          ticks;
      logic [1:0]  exp_type;
      logic [15:0] exp_led;
      bit          sat;
   } vec_t;

   vec_t vec[6];

   morse_symbol_capture dut (
      .clock100Hz   (clock100Hz),
      .clear        (clear),
      .btnR         (btnR),
      .btnL         (btnL),
      .type_o       (type_o),
      .letter_valid (letter_valid),
      .letter_ready (letter_ready),
      .letter_code  (letter_code),
      .letter_len   (letter_len),
      .word_gap     (word_gap),
      .overflow     (overflow),
      .led          (led)
   );

   always #5 clock100Hz = ~clock100Hz;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock100Hz);
   endtask

   task automatic do_reset();
      clear = 1'b0;
      btnR = 1'b0;
      btnL = 1'b0;
      tick(3);
      clear = 1'b1;
   endtask

   // Leaves the bench one negedge after the falling edge was sampled.
   task automatic press(input int n);
      btnR = 1'b1;
      tick(n);
      btnR = 1'b0;
      tick(1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " type"}, 32'(type_o), 32'(2'b11));
      chk({tag, " valid"}, 32'(letter_valid), 0);
      chk({tag, " code"}, 32'(letter_code), 0);
      chk({tag, " len"}, 32'(letter_len), 0);
      chk({tag, " word_gap"}, 32'(word_gap), 0);
      chk({tag, " overflow"}, 32'(overflow), 0);
      chk({tag, " led"}, 32'(led), 0);
   endtask

   initial begin
      logic [11:0] exp_code;
      bit          seen;

      vec[0] = '{30,  2'b01, 16'h8000, 1'b0};
      vec[1] = '{70,  2'b10, 16'hB800, 1'b0};
      vec[2] = '{69,  2'b01, 16'hBA00, 1'b0};
      vec[3] = '{250, 2'b10, 16'hBAE0, 1'b1};
      vec[4] = '{1,   2'b01, 16'hBAE8, 1'b0};
      vec[5] = '{71,  2'b10, 16'hBAE8, 1'b0};

      // Single DOT, letter close and word gap timing
      do_reset();
      tick(1);
      chk_reset_outs("reset");
      press(30);
      chk("dot type", 32'(type_o), 32'(2'b01));
      chk("dot led", 32'(led), 32'h8000);
      tick(1);
      chk("dot type back to stop", 32'(type_o), 32'(2'b11));
      tick(147);
      chk("valid before 150", 32'(letter_valid), 0);
      tick(1);
      chk("valid at 150", 32'(letter_valid), 1);
      chk("gap type", 32'(type_o), 32'(2'b00));
      chk("len 1", 32'(letter_len), 1);
      chk("code lsb", 32'(letter_code[1:0]), 32'(2'b01));
      chk("led cleared", 32'(led), 0);
      tick(199);
      chk("word_gap before 350", 32'(word_gap), 0);
      tick(1);
      chk("word_gap at 350", 32'(word_gap), 1);
      tick(1);
      chk("word_gap one cycle", 32'(word_gap), 0);

      // Press-length table: one letter of six symbols
      do_reset();
      exp_code = '0;
      for (int i = 0; i < 6; i++) begin
         btnR = 1'b1;
         tick(vec[i].ticks);
         if (vec[i].sat)
            chk("press saturation", 32'(dut.press_q), 100);
         btnR = 1'b0;
         tick(1);
         chk($sformatf("vec%0d type", i), 32'(type_o),
             32'(vec[i].exp_type));
         chk($sformatf("vec%0d led", i), 32'(led), 32'(vec[i].exp_led));
         exp_code = {exp_code[9:0], vec[i].exp_type};
         if (i < 5) tick(4);
      end
      chk("table overflow", 32'(overflow), 0);
      tick(149);
      chk("table valid", 32'(letter_valid), 1);
      chk("table len", 32'(letter_len), 6);
      chk("table code", 32'(letter_code), 32'(exp_code));

      // Seven DOTs: seventh dropped
      do_reset();
      for (int i = 0; i < 7; i++) begin
         press(5);
         chk($sformatf("7dot type%0d", i), 32'(type_o), 32'(2'b01));
         if (i == 5) chk("6dot overflow", 32'(overflow), 0);
         if (i < 6) tick(2);
      end
      chk("7dot overflow", 32'(overflow), 1);
      chk("7dot led", 32'(led), 32'hAAA0);
      tick(149);
      chk("7dot valid", 32'(letter_valid), 1);
      chk("7dot len", 32'(letter_len), 6);
      chk("7dot code", 32'(letter_code), 32'h555);

      // Back-pressure: second letter dropped, accept clears overflow
      do_reset();
      letter_ready = 1'b0;
      press(5);
      tick(149);
      chk("bp first valid", 32'(letter_valid), 1);
      chk("bp first code", 32'(letter_code), 32'h001);
      press(80);
      tick(4);
      press(80);
      tick(149);
      chk("bp still valid", 32'(letter_valid), 1);
      chk("bp held code", 32'(letter_code), 32'h001);
      chk("bp held len", 32'(letter_len), 1);
      chk("bp overflow", 32'(overflow), 1);
      letter_ready = 1'b1;
      tick(1);
      chk("bp valid falls", 32'(letter_valid), 0);
      chk("bp overflow clears", 32'(overflow), 0);
      letter_ready = 1'b0;

      // Flush coinciding with a falling key edge
      do_reset();
      letter_ready = 1'b1;
      press(5);
      chk("flush pre led", 32'(led), 32'h8000);
      tick(3);
      btnR = 1'b1;
      tick(5);
      btnR = 1'b0;
      btnL = 1'b1;
      tick(1);
      chk("flush type", 32'(type_o), 32'(2'b00));
      chk("flush led", 32'(led), 0);
      chk("flush buffer", 32'(dut.cnt_q), 0);
      btnL = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (letter_valid) seen = 1'b1;
      end
      chk("flush no letter", 32'(seen), 0);
      letter_ready = 1'b0;

      // Reset in the middle of a press with a letter pending
      do_reset();
      press(5);
      tick(149);
      chk("mid pre valid", 32'(letter_valid), 1);
      btnR = 1'b1;
      tick(10);
      clear = 1'b0;
      tick(1);
      chk_reset_outs("mid reset");
      tick(2);
      clear = 1'b1;
      tick(20);
      btnR = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (type_o != 2'b11 || letter_valid) seen = 1'b1;
      end
      chk("no symbol after reset", 32'(seen), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
